// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types and constants for the stream_mux block.
//   mode_e      : arbitration mode (MODE_FIXED = 0, MODE_RR = 1)
//   XFER_CNT_W  : width of the optional output-transfer counter
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int XFER_CNT_W = 32;

endpackage

// File: rtl/stream_mux_rr.sv
// rr_arbiter: round-robin grant selection for stream_mux.
// Searches upward from rr_ptr (wrapping at NCH-1) for the first valid
// channel.  rr_ptr moves to grant+1 (wrapping to 0 at NCH) only when the
// parent reports a round-robin transfer through 'advance'.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears rr_ptr)
//   valid       : per-channel request
//   advance     : a round-robin transfer on 'grant' happens this edge
//   grant_vld   : at least one channel is requesting
//   grant       : index of the selected channel
module rr_arbiter #(
  parameter int NCH   = 4,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   valid,
  input  logic             advance,
  output logic             grant_vld,
  output logic [SEL_W-1:0] grant
);

  logic [SEL_W-1:0] rr_ptr;

  // Walk offsets from highest to lowest so the smallest offset from rr_ptr
  // is the last writer and therefore wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (valid[SEL_W'(idx)]) begin
        grant_vld = 1'b1;
        grant     = SEL_W'(idx);
      end
    end
  end

  // Explicit compare against NCH-1 so non-power-of-two NCH wraps correctly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (int'(grant) == NCH - 1) ? '0 : grant + SEL_W'(1);
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel to 1 stream multiplexer with a single registered
// output stage (EMPTY/FULL), fixed-select or round-robin arbitration.
// Optional feature: define STREAM_MUX_STATS_EN to add o_xfer_cnt, a
// saturating count of output transfers.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_data/i_valid : NCH input channels (channel k at [k*WIDTH +: WIDTH])
//   o_ready        : per-channel ready, combinational, one-hot or zero
//   i_mode         : 0 fixed select via i_ctrl, 1 round-robin
//   i_ctrl         : selected channel in fixed mode (>= NCH: no grant)
//   o_data/o_valid : registered output word and valid
//   i_ready        : downstream ready
//   o_ch           : source channel of o_data
//   o_xfer_cnt     : output transfer count (STREAM_MUX_STATS_EN only)
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NCH*WIDTH-1:0] i_data,
  input  logic [NCH-1:0]       i_valid,
  output logic [NCH-1:0]       o_ready,
  input  logic                 i_mode,
  input  logic [SEL_W-1:0]     i_ctrl,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SEL_W-1:0]     o_ch
`ifdef STREAM_MUX_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0] o_xfer_cnt
`endif
);

  mode_e            mode;
  logic             can_load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_grant;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             load;
  logic             advance;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] ch_p1;

  assign mode = mode_e'(i_mode);

  rr_arbiter #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_rr (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .valid     (i_valid),
    .advance   (advance),
    .grant_vld (rr_vld),
    .grant     (rr_grant)
  );

  // Stage 0: grant selection and input handshake
  always_comb begin
    can_load  = !vld_p1 || i_ready;
    grant_vld = 1'b0;
    grant     = i_ctrl;
    if (mode == MODE_RR) begin
      grant_vld = rr_vld;
      grant     = rr_grant;
    end else begin
      // Widen before comparing so power-of-two NCH does not give a constant compare.
      grant_vld = (int'(i_ctrl) < NCH);
    end

    o_ready   = '0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (SEL_W'(k) == grant) begin
        o_ready[k] = i_rst_n && can_load && grant_vld;
        sel_valid  = i_valid[k];
        sel_data   = i_data[k*WIDTH +: WIDTH];
      end
    end

    load    = i_rst_n && can_load && grant_vld && sel_valid;
    advance = load && (mode == MODE_RR);
  end

  // Stage 1: output register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      ch_p1   <= grant;
    end else if (i_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_ch    = ch_p1;

`ifdef STREAM_MUX_STATS_EN
  logic [XFER_CNT_W-1:0] xfer_cnt;

  function automatic logic [XFER_CNT_W-1:0] sat_inc(input logic [XFER_CNT_W-1:0] v);
    return (v == '1) ? v : v + XFER_CNT_W'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      xfer_cnt <= '0;
    end else if (vld_p1 && i_ready) begin
      xfer_cnt <= sat_inc(xfer_cnt);
    end
  end

  assign o_xfer_cnt = xfer_cnt;
`endif

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: self-checking bench for stream_mux (NCH=4 and NCH=3 instances).
// A negedge scoreboard predicts o_ready/o_valid and the word held in the
// output register for the NCH=4 instance; scenario tasks add directed checks.
// Build with STREAM_MUX_STATS_EN defined to also exercise o_xfer_cnt.
module tb_stream_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // NCH=4 instance signals
  logic [63:0] data4;
  logic [3:0]  valid4;
  logic [3:0]  ordy4;
  logic        mode4;
  logic [1:0]  ctrl4;
  logic [15:0] odata4;
  logic        ovalid4;
  logic        iready4;
  logic [1:0]  och4;
  // NCH=3 instance signals
  logic [47:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  ordy3;
  logic        mode3;
  logic [1:0]  ctrl3;
  logic [15:0] odata3;
  logic        ovalid3;
  logic        iready3;
  logic [1:0]  och3;
`ifdef STREAM_MUX_STATS_EN
  logic [31:0] cnt4;
  logic [31:0] cnt3;
`endif

  stream_mux #(.WIDTH(16), .NCH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data4), .i_valid(valid4),
    .o_ready(ordy4), .i_mode(mode4), .i_ctrl(ctrl4), .o_data(odata4),
    .o_valid(ovalid4), .i_ready(iready4), .o_ch(och4)
`ifdef STREAM_MUX_STATS_EN
    , .o_xfer_cnt(cnt4)
`endif
  );

  stream_mux #(.WIDTH(16), .NCH(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data3), .i_valid(valid3),
    .o_ready(ordy3), .i_mode(mode3), .i_ctrl(ctrl3), .o_data(odata3),
    .o_valid(ovalid3), .i_ready(iready3), .o_ch(och3)
`ifdef STREAM_MUX_STATS_EN
    , .o_xfer_cnt(cnt3)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard state for the NCH=4 instance
  bit          mon_en = 1'b0;
  bit          m_full = 1'b0;
  int          m_ptr  = 0;
  logic [15:0] q_data[$];
  logic [1:0]  q_ch[$];

  always @(negedge clk) begin
    bit       can, gv, acc, ox;
    int       g, c;
    logic [3:0] er;
    if (mon_en) begin
      n_checks++;
      if (ovalid4 !== m_full) begin
        n_errors++;
        $display("FAIL sb_valid: got %0b expected %0b at %0t", ovalid4, m_full, $time);
      end
      if (m_full && q_data.size() > 0) begin
        n_checks++;
        if (odata4 !== q_data[0] || och4 !== q_ch[0]) begin
          n_errors++;
          $display("FAIL sb_word: got data %h ch %0d expected data %h ch %0d at %0t",
                   odata4, och4, q_data[0], q_ch[0], $time);
        end
      end
      can = !m_full || iready4;
      gv  = 1'b0;
      g   = 0;
      if (mode4) begin
        for (int i = 0; i < 4; i++) begin
          c = (m_ptr + i) % 4;
          if (!gv && valid4[c]) begin
            gv = 1'b1;
            g  = c;
          end
        end
      end else begin
        gv = 1'b1;
        g  = int'(ctrl4);
      end
      er = (rst_n && can && gv) ? 4'(1 << g) : 4'b0000;
      n_checks++;
      if (ordy4 !== er) begin
        n_errors++;
        $display("FAIL sb_ready: got %b expected %b at %0t", ordy4, er, $time);
      end
      if (!rst_n) begin
        m_full = 1'b0;
        m_ptr  = 0;
        q_data.delete();
        q_ch.delete();
      end else begin
        ox  = m_full && iready4;
        acc = can && gv && valid4[g];
        if (ox) begin
          void'(q_data.pop_front());
          void'(q_ch.pop_front());
        end
        if (acc) begin
          q_data.push_back(data4[g*16 +: 16]);
          q_ch.push_back(2'(g));
          if (mode4) m_ptr = (g + 1) % 4;
        end
        m_full = acc || (m_full && !ox);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data4 = '0; valid4 = 4'hF; mode4 = 1'b1; ctrl4 = '0; iready4 = 1'b1;
    data3 = '0; valid3 = '0; mode3 = 1'b0; ctrl3 = '0; iready3 = 1'b1;
    tick(); tick();
    mon_en = 1'b1;
    n_checks++;
    if (ovalid4 !== 1'b0 || odata4 !== 16'h0 || och4 !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_out: got v=%b d=%h ch=%0d expected 0/0000/0", ovalid4, odata4, och4);
    end
    n_checks++;
    if (ordy4 !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ready: got %b expected 0000", ordy4);
    end
    n_checks++;
    if (ovalid3 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out3: got v=%b expected 0", ovalid3);
    end
    valid4 = '0;
    rst_n  = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    mode4 = 1'b0; ctrl4 = 2'd2; iready4 = 1'b1;
    data4[2*16 +: 16] = 16'hA5A5; valid4 = 4'b0100;
    #1;
    n_checks++;
    if (ordy4 !== 4'b0100) begin
      n_errors++;
      $display("FAIL fixed_ready: got %b expected 0100", ordy4);
    end
    tick();
    valid4 = '0;
    n_checks++;
    if (ovalid4 !== 1'b1 || odata4 !== 16'hA5A5 || och4 !== 2'd2) begin
      n_errors++;
      $display("FAIL fixed_out: got v=%b d=%h ch=%0d expected 1/a5a5/2", ovalid4, odata4, och4);
    end
    // Other channels valid but ch2 idle: ready stays on ch2, nothing loads.
    valid4 = 4'b1011;
    #1;
    n_checks++;
    if (ordy4 !== 4'b0100) begin
      n_errors++;
      $display("FAIL fixed_ready_idle: got %b expected 0100", ordy4);
    end
    tick();
    valid4 = '0;
    n_checks++;
    if (ovalid4 !== 1'b0) begin
      n_errors++;
      $display("FAIL fixed_no_load: got v=%b expected 0", ovalid4);
    end
  endtask

  task automatic test_back_to_back();
    mode4 = 1'b1; iready4 = 1'b1; valid4 = 4'hF;
    for (int k = 0; k < 4; k++) data4[k*16 +: 16] = 16'h1000 + 16'(k);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (ordy4 !== 4'(1 << (i % 4))) begin
        n_errors++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", i, ordy4, 4'(1 << (i % 4)));
      end
      tick();
      n_checks++;
      if (ovalid4 !== 1'b1 || och4 !== 2'(i % 4)) begin
        n_errors++;
        $display("FAIL rr_out[%0d]: got v=%b ch=%0d expected 1/%0d", i, ovalid4, och4, i % 4);
      end
    end
    valid4 = '0;
    tick();
  endtask

  task automatic test_backpressure();
    mode4 = 1'b0; ctrl4 = 2'd1; iready4 = 1'b1;
    data4[1*16 +: 16] = 16'h1234; valid4 = 4'b0010;
    tick();
    iready4 = 1'b0;
    data4[1*16 +: 16] = 16'h5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (ovalid4 !== 1'b1 || odata4 !== 16'h1234 || och4 !== 2'd1 || ordy4 !== 4'b0000) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d rdy=%b expected 1/1234/1/0000",
                 i, ovalid4, odata4, och4, ordy4);
      end
      tick();
    end
    iready4 = 1'b1;
    #1;
    n_checks++;
    if (ordy4 !== 4'b0010) begin
      n_errors++;
      $display("FAIL bp_release_ready: got %b expected 0010", ordy4);
    end
    tick();
    valid4 = '0;
    n_checks++;
    if (ovalid4 !== 1'b1 || odata4 !== 16'h5678) begin
      n_errors++;
      $display("FAIL bp_no_bubble: got v=%b d=%h expected 1/5678", ovalid4, odata4);
    end
    tick();
    n_checks++;
    if (ovalid4 !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain: got v=%b expected 0", ovalid4);
    end
  endtask

  task automatic test_nch3();
    logic [1:0] exp_ch[4];
    logic [2:0] vals[4];
    vals[0] = 3'b100; exp_ch[0] = 2'd2;
    vals[1] = 3'b111; exp_ch[1] = 2'd0;
    vals[2] = 3'b111; exp_ch[2] = 2'd1;
    vals[3] = 3'b111; exp_ch[3] = 2'd2;
    mode3 = 1'b1; iready3 = 1'b1;
    for (int k = 0; k < 3; k++) data3[k*16 +: 16] = 16'h0C00 + 16'(k);
    for (int i = 0; i < 4; i++) begin
      valid3 = vals[i];
      #1;
      n_checks++;
      if (ordy3 !== 3'(1 << exp_ch[i])) begin
        n_errors++;
        $display("FAIL nch3_ready[%0d]: got %b expected %b", i, ordy3, 3'(1 << exp_ch[i]));
      end
      tick();
      n_checks++;
      if (ovalid3 !== 1'b1 || och3 !== exp_ch[i] || odata3 !== 16'h0C00 + 16'(exp_ch[i])) begin
        n_errors++;
        $display("FAIL nch3_out[%0d]: got v=%b ch=%0d d=%h expected 1/%0d", i, ovalid3, och3, odata3, exp_ch[i]);
      end
    end
    mode3 = 1'b0; ctrl3 = 2'd3; valid3 = 3'b111;
    #1;
    n_checks++;
    if (ordy3 !== 3'b000) begin
      n_errors++;
      $display("FAIL nch3_ctrl_oob_ready: got %b expected 000", ordy3);
    end
    tick();
    n_checks++;
    if (ovalid3 !== 1'b0) begin
      n_errors++;
      $display("FAIL nch3_ctrl_oob_load: got v=%b expected 0", ovalid3);
    end
    ctrl3 = 2'd1;
    #1;
    n_checks++;
    if (ordy3 !== 3'b010) begin
      n_errors++;
      $display("FAIL nch3_ctrl_change: got %b expected 010", ordy3);
    end
    valid3 = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    mode4 = 1'b1; iready4 = 1'b1; valid4 = 4'b0010;
    tick();
    mode4 = 1'b0; ctrl4 = 2'd0; data4[0 +: 16] = 16'hBEEF; valid4 = 4'b0001;
    tick();
    valid4 = '0; iready4 = 1'b0;
    tick();
    n_checks++;
    if (ovalid4 !== 1'b1 || odata4 !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL rstmid_full: got v=%b d=%h expected 1/beef", ovalid4, odata4);
    end
    rst_n = 1'b0; mode4 = 1'b1; valid4 = 4'hF; iready4 = 1'b1;
    #1;
    n_checks++;
    if (ordy4 !== 4'b0000) begin
      n_errors++;
      $display("FAIL rstmid_ready: got %b expected 0000", ordy4);
    end
    tick();
    n_checks++;
    if (ovalid4 !== 1'b0 || odata4 !== 16'h0 || och4 !== 2'd0) begin
      n_errors++;
      $display("FAIL rstmid_out: got v=%b d=%h ch=%0d expected 0/0000/0", ovalid4, odata4, och4);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ordy4 !== 4'b0001) begin
      n_errors++;
      $display("FAIL rstmid_rr_restart: got %b expected 0001", ordy4);
    end
    tick();
    valid4 = '0;
    tick();
  endtask

`ifdef STREAM_MUX_STATS_EN
  task automatic test_stats();
    logic [31:0] base;
    base = cnt4;
    mode4 = 1'b0; ctrl4 = 2'd0; iready4 = 1'b1; valid4 = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      data4[0 +: 16] = 16'h2000 + 16'(i);
      tick();
    end
    valid4 = '0;
    tick();
    n_checks++;
    if (cnt4 !== base + 32'd10) begin
      n_errors++;
      $display("FAIL stats_count: got %0d expected %0d", cnt4, base + 32'd10);
    end
    dut.xfer_cnt = 32'hFFFF_FFFE;
    valid4 = 4'b0001;
    tick(); tick(); tick();
    valid4 = '0;
    tick();
    n_checks++;
    if (cnt4 !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL stats_saturate: got %h expected ffffffff", cnt4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back();
    test_backpressure();
    test_nch3();
    test_reset_mid();
`ifdef STREAM_MUX_STATS_EN
    test_stats();
`endif
    tick();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the data width per channel in bits.
REQ-002 The module SHALL have parameter NCH, default 4, meaning the number of input channels, legal range 2..16.
REQ-003 The module SHALL have parameter SEL_W, default $clog2(NCH), meaning the width of the channel index.
REQ-004 Port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 Port i_data, input, NCH*WIDTH bits: channel k data occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port i_valid, input, NCH bits: per-channel valid.
REQ-008 Port o_ready, output, NCH bits: per-channel ready, combinational.
REQ-009 Port i_mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-010 Port i_ctrl, input, SEL_W bits: selected channel in fixed mode.
REQ-011 Port o_data, output, WIDTH bits: registered output data.
REQ-012 Port o_valid, output, 1 bit: registered output valid.
REQ-013 Port i_ready, input, 1 bit: downstream ready.
REQ-014 Port o_ch, output, SEL_W bits: source channel of the current o_data.

Function
REQ-015 Transfers SHALL occur on channel k when i_valid[k] and o_ready[k] are both 1 at a rising edge, and at the output when o_valid and i_ready are both 1.
REQ-016 The output stage SHALL be a single register with states EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-017 The output stage SHALL be able to load when it is EMPTY or when i_ready=1 in the same cycle, allowing a simultaneous drain and load for full throughput.
REQ-018 When the output stage can load, o_ready[g] SHALL be 1 only for the granted channel g; all other o_ready bits SHALL be 0.
REQ-019 When the output stage cannot load, o_ready SHALL be all 0.
REQ-020 Latency SHALL be 1 cycle: data accepted at edge n appears on o_data/o_valid after edge n.
REQ-021 In fixed mode, g SHALL equal i_ctrl.
REQ-022 In fixed mode, if i_ctrl >= NCH, no grant SHALL be issued, o_ready SHALL be all 0, and the output stage SHALL only drain.
REQ-023 In round-robin mode, g SHALL be the first channel with i_valid=1, searching upward from rr_ptr and wrapping from NCH-1 to 0.
REQ-024 In round-robin mode, if no channel is valid, no grant SHALL be issued.
REQ-025 After a round-robin input transfer on channel g, rr_ptr SHALL become g+1, wrapping to 0 at NCH, including when NCH is not a power of two.
REQ-026 rr_ptr SHALL be unchanged by cycles with no transfer and by fixed-mode transfers.
REQ-027 A change of i_mode or i_ctrl SHALL take effect in the same cycle, and the held output word SHALL be unaffected.
REQ-028 While o_valid=1 and i_ready=0, o_data and o_ch SHALL hold stable.
REQ-029 o_ch SHALL be loaded with g together with o_data.

Reset
REQ-030 When i_rst_n=0 at an edge, o_valid, o_data, o_ch and rr_ptr SHALL become 0 (plus the counter of REQ-033 when compiled in).
REQ-031 Reset mid-operation SHALL discard any held word.
REQ-032 o_ready SHALL be all 0 while i_rst_n=0.

Configuration
REQ-033 With macro STREAM_MUX_STATS_EN defined, the module SHALL add output port o_xfer_cnt (32 bits), which counts output transfers, saturates at 0xFFFFFFFF, and resets to 0.
REQ-034 Without STREAM_MUX_STATS_EN, neither the port o_xfer_cnt nor its logic SHALL exist.

Structure
REQ-035 Package stream_mux_pkg SHALL hold the mode enum (MODE_FIXED=0, MODE_RR=1) and the counter width constant XFER_CNT_W=32.
REQ-036 Round-robin grant selection and rr_ptr SHALL live in sub-module rr_arbiter, parametrised by NCH.
REQ-037 The top level SHALL hold the fixed-mode select, the output register and the counter.

Verification
REQ-038 Fixed mode, i_ctrl=2, ch2 sends 0xA5A5, i_ready=1 -> o_data=0xA5A5, o_ch=2, o_valid=1 exactly one cycle later; o_ready=4'b0100.
REQ-039 Round-robin, all 4 channels valid continuously, i_ready=1 -> grants 0,1,2,3,0 on consecutive cycles with one transfer per cycle.
REQ-040 Backpressure: output FULL with 0x1234 and i_ready=0 for 5 cycles -> o_data=0x1234 stable and o_ready=0; on the cycle i_ready rises, a new word is loaded with no bubble.
REQ-041 NCH=3, round-robin, only ch2 valid then ch0 valid -> rr_ptr wraps 2->0 and ch0 is granted; fixed mode with i_ctrl=3 -> o_ready=0 and no load.
REQ-042 i_rst_n=0 for 1 cycle while FULL -> o_valid=0, o_data=0, o_ch=0 after the edge, and the next RR grant starts at ch0.
REQ-043 With STREAM_MUX_STATS_EN, 10 output transfers -> o_xfer_cnt=10; when forced to 0xFFFFFFFE, 3 further transfers -> 0xFFFFFFFF.
